instr_fetch_unit: RTL and testbench

Instruction fetch stage of the single-cycle/pipelined SimpleCPU core. Holds the program counter, drives the byte address into the instruction ROM, and captures the returned 32-bit big-endian word into the IF/ID pipeline register together with its PC. It also handles stall, branch/jump redirect and misaligned-target faults.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/if_id_reg.sv | 58 +++++
 rtl/instr_fetch_unit.sv | 121 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared SimpleCPU definitions used by the fetch stage and its IF/ID register.
package cpu_pkg;

    localparam int          INSTR_W   = 32;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush clears the slot, load captures, otherwise hold.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [31:0]        pc_in,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_pc_plus4
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        pc_plus4_q, pc_plus4_d;

    always_comb begin
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        // Flush wins so a squashed slot never carries a stale word.
        if (flush) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (load) begin
            valid_d    = 1'b1;
            instr_d    = instr_in;
            pc_d       = pc_in;
            pc_plus4_d = pc_in + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_q       <= 32'd0;
            pc_plus4_q <= 32'd0;
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign id_valid    = valid_q;
    assign id_instr    = instr_q;
    assign id_pc       = pc_q;
    assign id_pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// SimpleCPU fetch stage: PC, BOOT/RUN/FAULT control and sticky fault.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles counters.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_ADDR_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_target,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_pc_plus4,
    output logic               fetch_fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_bubbles
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         fault_q, fault_d;
    logic         load, flush;
    logic         out_of_window;

    // Any address bit at or above the window width means the fetch left the ROM.
    assign out_of_window = (pc_q >> IMEM_ADDR_W) != 32'd0;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        load    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                    flush   = 1'b1;
                end else if (redirect_valid) begin
                    pc_d  = redirect_target;
                    flush = 1'b1;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (out_of_window) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                    flush   = 1'b1;
                end else begin
                    load = 1'b1;
                    pc_d = pc_q + PC_STEP;
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .flush       (flush),
        .instr_in    (imem_rdata),
        .pc_in       (pc_q),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4)
    );

    assign imem_addr   = pc_q;
    assign fetch_fault = fault_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] bubbles_q, bubbles_d;

    // Every RUN edge that does not capture is a redirect, stall or fault bubble.
    always_comb begin
        fetched_d = fetched_q + (load ? 32'd1 : 32'd0);
        bubbles_d = bubbles_q + (((state_q == RUN) && !load) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetched_q <= 32'd0;
            bubbles_q <= 32'd0;
        end else begin
            fetched_q <= fetched_d;
            bubbles_q <= bubbles_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random stall/redirect traffic.
module tb_instr_fetch_unit;

    localparam int AW    = 10;
    localparam int WORDS = 2 ** (AW - 2);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        fetch_fault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    logic [31:0] rom [WORDS];

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_idpc, m_idpc4;
    logic        m_valid, m_fault, m_boot, m_dead;
    logic [31:0] m_fetched, m_bubbles;

    always #5 clk = ~clk;

    assign imem_rdata = rom[imem_addr[AW-1:2]];

    instr_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .IMEM_ADDR_W (AW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .id_valid        (id_valid),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_pc_plus4     (id_pc_plus4),
        .fetch_fault     (fetch_fault)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_bubbles    (perf_bubbles)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rom_at(input logic [31:0] a);
        return rom[(a >> 2) % WORDS];
    endfunction

    // Apply the spec's per-edge rules to the model, using the inputs about to be sampled.
    task automatic model_edge();
        if (!rst_n) begin
            m_pc = 32'd0; m_instr = 32'd0; m_idpc = 32'd0; m_idpc4 = 32'd0;
            m_valid = 1'b0; m_fault = 1'b0; m_boot = 1'b1; m_dead = 1'b0;
            m_fetched = 32'd0; m_bubbles = 32'd0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (!m_dead) begin
            if (redirect_valid && (redirect_target % 4 != 0)) begin
                m_dead = 1'b1; m_fault = 1'b1; m_valid = 1'b0; m_instr = 32'd0;
                m_bubbles++;
            end else if (redirect_valid) begin
                m_pc = redirect_target; m_valid = 1'b0; m_instr = 32'd0;
                m_bubbles++;
            end else if (stall) begin
                m_bubbles++;
            end else if (m_pc >= 32'(2 ** AW)) begin
                m_dead = 1'b1; m_fault = 1'b1; m_valid = 1'b0; m_instr = 32'd0;
                m_bubbles++;
            end else begin
                m_instr = rom_at(m_pc); m_idpc = m_pc; m_idpc4 = m_pc + 32'd4;
                m_valid = 1'b1; m_pc = m_pc + 32'd4;
                m_fetched++;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic s, input logic rv, input logic [31:0] rt);
        rst_n = r; stall = s; redirect_valid = rv; redirect_target = rt;
        model_edge();
        @(posedge clk);
        #1;
        check_eq("imem_addr", imem_addr, m_pc);
        check_eq("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
        check_eq("id_instr", id_instr, m_instr);
        check_eq("id_pc", id_pc, m_idpc);
        check_eq("id_pc_plus4", id_pc_plus4, m_idpc4);
        check_eq("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
`ifdef FETCH_PERF_CNT_EN
        check_eq("perf_fetched", perf_fetched, m_fetched);
        check_eq("perf_bubbles", perf_bubbles, m_bubbles);
`endif
        $display("cyc rst_n=%0b stall=%0b rv=%0b tgt=%08h -> addr=%08h v=%0b instr=%08h pc=%08h flt=%0b",
                 r, s, rv, rt, imem_addr, id_valid, id_instr, id_pc, fetch_fault);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        logic [31:0] tgt;
        logic        r, s, rv;

        for (int i = 0; i < WORDS; i++) rom[i] = $urandom;
        rom[0] = 32'h1111_1111;
        rom[1] = 32'h2222_2222;
        rom[2] = 32'h3333_3333;

        // Reset and free-run
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check_eq("rst_id_instr", id_instr, 32'h0000_0000);
        check_eq("rst_imem_addr", imem_addr, 32'h0000_0000);
        run(1);
        check_eq("boot_no_capture", {31'd0, id_valid}, 32'd0);
        run(1);
        check_eq("first_instr", id_instr, 32'h1111_1111);
        check_eq("first_pc", id_pc, 32'h0);
        run(1);
        check_eq("second_instr", id_instr, 32'h2222_2222);

        // Stall three cycles at id_pc=4
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        check_eq("stall_addr", imem_addr, 32'h8);
        check_eq("stall_id_pc", id_pc, 32'h4);
        run(1);
        check_eq("resume_instr", id_instr, 32'h3333_3333);
        check_eq("resume_pc", id_pc, 32'h8);
        run(1);

        // Redirect from pc=0x10 to 0x40
        cycle(1'b1, 1'b0, 1'b1, 32'h40);
        check_eq("redir_bubble", {31'd0, id_valid}, 32'd0);
        check_eq("redir_addr", imem_addr, 32'h40);
        run(1);
        check_eq("redir_target_pc", id_pc, 32'h40);

        // Redirect beats stall
        cycle(1'b1, 1'b1, 1'b1, 32'h80);
        check_eq("redir_over_stall", imem_addr, 32'h80);
        run(2);

        // Misaligned redirect faults until reset
        cycle(1'b1, 1'b0, 1'b1, 32'h42);
        check_eq("misalign_fault", {31'd0, fetch_fault}, 32'd1);
        run(3);
        check_eq("fault_no_valid", {31'd0, id_valid}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check_eq("fault_cleared", {31'd0, fetch_fault}, 32'd0);
        check_eq("pc_after_reset", imem_addr, 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r  = !((m_dead && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 99) == 0));
            s  = ($urandom_range(0, 9) < 3);
            rv = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 9))
                0:       tgt = 32'($urandom_range(0, WORDS - 1)) * 4 + 32'($urandom_range(1, 3));
                1:       tgt = 32'h3F8;
                default: tgt = 32'($urandom_range(0, WORDS - 1)) * 4;
            endcase
            cycle(r, s, rv, tgt);
        end

        // Free-run off the end of the window
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        run(1 + WORDS);
        check_eq("last_pc", id_pc, 32'h3FC);
        check_eq("window_no_fault_yet", {31'd0, fetch_fault}, 32'd0);
        run(1);
        check_eq("window_fault", {31'd0, fetch_fault}, 32'd1);
        check_eq("window_no_capture", {31'd0, id_valid}, 32'd0);
        check_eq("window_pc_frozen", imem_addr, 32'h400);
`ifdef FETCH_PERF_CNT_EN
        check_eq("perf_256", perf_fetched, 32'd256);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
